// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence engine: state encoding and default sizes.
package fib_pkg;

    localparam int FIB_W  = 16;
    localparam int FIB_CW = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_ITER = S_ITER,
        ST_FIN  = S_FIN
    } state_t;

endpackage

// File: rtl/fib_seq_engine_if.sv
// Request/result bundle of the Fibonacci engine. Stream signals exist only with FIB_STREAM_EN.
//
// Handshake: start is a level request, taken only on an edge where the engine is idle
// (busy low); n is sampled on that same edge. done is a one-cycle strobe marking
// result/overflow valid; they hold until the next accepted start. There is no ready
// back-pressure on done. term_valid is a one-cycle strobe qualifying term.
interface fib_seq_engine_if import fib_pkg::*; #(
    parameter int W  = FIB_W,
    parameter int CW = FIB_CW
);
    logic          start;
    logic          abort;
    logic [CW-1:0] n;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          overflow;
    logic [1:0]    state;
`ifdef FIB_STREAM_EN
    logic [W-1:0]  term;
    logic          term_valid;

    modport master (
        output start, abort, n,
        input  busy, done, result, overflow, state, term, term_valid
    );
    modport slave (
        input  start, abort, n,
        output busy, done, result, overflow, state, term, term_valid
    );
`else
    modport master (
        output start, abort, n,
        input  busy, done, result, overflow, state
    );
    modport slave (
        input  start, abort, n,
        output busy, done, result, overflow, state
    );
`endif
endinterface

// File: rtl/fib_datapath.sv
// Two-register Fibonacci datapath: a holds F(i), b holds F(i+1), both modulo 2^W,
// with sticky flags recording whether either term ever wrapped.
module fib_datapath #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         carry,
    output logic         aov
);
    logic [W:0] sum;
    logic       bov;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign carry = sum[W];

    // The overflow flag travels with its term, so a wrap in b only reaches aov one step later.
    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= '0;
            b   <= '0;
            aov <= 1'b0;
            bov <= 1'b0;
        end else if (load) begin
            a   <= '0;
            b   <= W'(1);
            aov <= 1'b0;
            bov <= 1'b0;
        end else if (step) begin
            a   <= b;
            b   <= sum[W-1:0];
            aov <= bov;
            bov <= bov | carry;
        end
    end
endmodule

// File: rtl/fib_seq_engine.sv
// Fibonacci engine top: control FSM, iteration counter and output registers around fib_datapath.
// Optional macro FIB_STREAM_EN adds the term/term_valid stream of F(1)..F(N).
module fib_seq_engine import fib_pkg::*; #(
    parameter int W  = FIB_W,
    parameter int CW = FIB_CW
) (
    input logic             clk,
    input logic             rst,
    fib_seq_engine_if.slave bus
);
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          load, step;
    logic [W-1:0]  a, b;
    logic          carry, aov;
    logic [W-1:0]  result_n;
    logic          overflow_n, done_n;

    fib_datapath #(.W(W)) u_datapath (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .a     (a),
        .b     (b),
        .carry (carry),
        .aov   (aov)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bus.result   <= '0;
            bus.overflow <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bus.result   <= result_n;
            bus.overflow <= overflow_n;
            bus.done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        load       = 1'b0;
        step       = 1'b0;
        result_n   = bus.result;
        overflow_n = bus.overflow;
        done_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    cnt_n      = bus.n;
                    result_n   = '0;
                    overflow_n = 1'b0;
                    state_n    = ST_ITER;
                end
            end
            ST_ITER: begin
                // Abort wins even on the cycle that would otherwise complete.
                if (bus.abort) begin
                    state_n = ST_IDLE;
                end else if (cnt != '0) begin
                    step  = 1'b1;
                    cnt_n = cnt - CW'(1);
                end else begin
                    result_n   = a;
                    overflow_n = aov;
                    done_n     = 1'b1;
                    state_n    = ST_FIN;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.busy  = (state != ST_IDLE);
    assign bus.state = state;

`ifdef FIB_STREAM_EN
    // Each step emits the old b, giving F(1)..F(N) in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.term       <= '0;
            bus.term_valid <= 1'b0;
        end else begin
            bus.term_valid <= step;
            if (step) bus.term <= b;
        end
    end

    logic unused_dp;
    assign unused_dp = carry;
`else
    logic unused_dp;
    assign unused_dp = ^{carry, b};
`endif
endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine (W=16, CW=6); stream checks build only with FIB_STREAM_EN.
module tb_fib_seq_engine;
    import fib_pkg::*;

    localparam int W  = 16;
    localparam int CW = 6;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [W:0] exp_q[$];   // {overflow, result} expected at each done

    fib_seq_engine_if #(.W(W), .CW(CW)) bus ();

    fib_seq_engine #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", bus.result, e[W-1:0]);
                check("overflow", bus.overflow, e[W]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Presents start for one edge; returns on the negedge after the accepting edge (j=0).
    task automatic start_run(input int nv, input bit push, input int er, input bit eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = CW'(nv);
        if (push) exp_q.push_back({eo, W'(er)});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = 0;
        for (int j = 0; j < budget; j++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        int n;
        int res;
        bit ovf;
    } vec_t;

    vec_t vecs[6] = '{
        '{10, 55,    1'b0},
        '{0,  0,     1'b0},
        '{1,  1,     1'b0},
        '{2,  1,     1'b0},
        '{24, 46368, 1'b0},
        '{25, 9489,  1'b1}
    };

    // ---------------- test sequence ----------------
    initial begin
        int lat, busy_cyc, done_cnt, t_first, t_second;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.n     = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_state", bus.state, S_IDLE);
`ifdef FIB_STREAM_EN
        check("rst_term", bus.term, 0);
        check("rst_term_valid", bus.term_valid, 0);
`endif
        rst = 1'b0;

        // Directed vectors: latency N+1, busy through ITER and FIN.
        foreach (vecs[i]) begin
            start_run(vecs[i].n, 1'b1, vecs[i].res, vecs[i].ovf);
            check("accept_state", bus.state, S_ITER);
            wait_done(200, lat, busy_cyc);
            check($sformatf("latency_n%0d", vecs[i].n), lat, vecs[i].n + 1);
            check($sformatf("busy_cycles_n%0d", vecs[i].n), busy_cyc, vecs[i].n + 2);
            @(negedge clk);
            check("done_one_cycle", bus.done, 0);
            check("idle_after_fin", bus.busy, 0);
            check("result_held", bus.result, vecs[i].res);
        end

        // Second start while busy is ignored, n not re-sampled.
        start_run(20, 1'b1, 6765, 1'b0);
        check("result_cleared_on_accept", bus.result, 0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.n     = CW'(5);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(200, lat, busy_cyc);
        check("latency_ignored_start", lat + 3, 21);
        @(negedge clk);

        // Abort at cycle 4: no done, busy drops, result stays cleared.
        start_run(10, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_result", bus.result, 0);
        check("abort_overflow", bus.overflow, 0);
        done_cnt = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // Reset mid-run.
        start_run(30, 1'b0, 0, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_overflow", bus.overflow, 0);
        check("midrst_state", bus.state, S_IDLE);
        start_run(3, 1'b1, 2, 1'b0);
        wait_done(200, lat, busy_cyc);
        check("latency_after_rst", lat, 4);
        @(negedge clk);

        // Start held high: re-accepted at the first idle edge, done pulses N+3 apart.
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = CW'(4);
        exp_q.push_back({1'b0, W'(3)});
        exp_q.push_back({1'b0, W'(3)});
        done_cnt = 0;
        t_first  = 0;
        t_second = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) t_first = j;
                else begin
                    t_second  = j;
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_done_count", done_cnt, 2);
        check("b2b_spacing", t_second - t_first, 7);
        repeat (3) @(negedge clk);
        check("b2b_no_third_run", bus.busy, 0);

`ifdef FIB_STREAM_EN
        begin
            logic [W-1:0] exp_terms[5];
            int k, first_j, done_j;
            exp_terms = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5};
            k = 0;
            first_j = -1;
            done_j = -1;
            start_run(5, 1'b1, 5, 1'b0);
            for (int j = 0; j < 40; j++) begin
                if (bus.term_valid) begin
                    if (first_j < 0) first_j = j;
                    if (k < 5) check($sformatf("term%0d", k), bus.term, exp_terms[k]);
                    k++;
                end
                if (bus.done) begin
                    done_j = j;
                    break;
                end
                @(negedge clk);
            end
            check("term_count", k, 5);
            check("term_first_cycle", first_j, 1);
            check("stream_done_cycle", done_j, 6);
            @(negedge clk);
            check("term_valid_idle", bus.term_valid, 0);
            check("term_hold", bus.term, 5);
        end
`endif

        repeat (4) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
